algo_1r1w_traffic_gen: RTL

- Synthesizable initiator and checker for the user-side 1r1w port of the algorithmic memory: drives write/read commands, predicts read data, and compares the returned rd_vld/rd_dout.
- Sits opposite the memory IP in the self-test harness. Its outputs connect to the IP's write/wr_adr/din/read/rd_adr; the IP's ready and read-response signals feed back into it.
- No shadow RAM. Expected data is a closed-form pattern of address and pass seed.

---
 rtl/algo_tg_pkg.sv | 22 ++
 rtl/algo_tg_exp_pipe.sv | 25 ++
 rtl/algo_1r1w_traffic_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/algo_tg_pkg.sv
// Shared types and helpers for the 1r1w algorithmic-memory traffic generator.
package algo_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITRDY,
    ST_FILL,
    ST_RW,
    ST_TAIL,
    ST_FINAL,
    ST_DRAIN,
    ST_DONE
  } tg_state_e;

  localparam logic [63:0] ERR_SAT = {64{1'b1}};

  // 32-bit base pattern: address XOR the seed replicated into every byte.
  function automatic logic [31:0] pat(input logic [31:0] a, input logic [7:0] s);
    return a ^ {4{s}};
  endfunction

endpackage

// File: rtl/algo_tg_exp_pipe.sv
// Delay line for the expected-read tuple {valid, addr, data}; clears on reset.
module algo_tg_exp_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/algo_1r1w_traffic_gen.sv
// Traffic initiator and response checker for the user-side 1r1w memory port.
// Expected read data is the closed-form pattern of address and pass seed.
//
// state   | meaning
// IDLE    | waiting for start
// WAITRDY | waiting for IP initialisation
// FILL    | write pat(adr,0) to every address
// RW      | read with previous seed, write trailing address with current seed
// TAIL    | write last address of the pass
// FINAL   | read-only sweep against the last seed
// DRAIN   | let outstanding reads return
// DONE    | run complete, results held
module algo_1r1w_traffic_gen
  import algo_tg_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 8192,
  parameter int BITADDR    = 13,
  parameter int READ_DELAY = 2,
  parameter int NUMPASS    = 4,
  parameter int ERRW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready,
  output logic               write,
  output logic [BITADDR-1:0] wr_adr,
  output logic [WIDTH-1:0]   din,
  output logic               read,
  output logic [BITADDR-1:0] rd_adr,
  input  logic               rd_vld,
  input  logic [WIDTH-1:0]   rd_dout,
  input  logic               rd_serr,
  input  logic               rd_derr,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [ERRW-1:0]    err_cnt,
  output logic [BITADDR-1:0] err_adr,
  output logic [7:0]         pass_cnt
);

  localparam int PW  = 1 + BITADDR + WIDTH;
  localparam int DCW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;
  localparam logic [BITADDR-1:0] LAST_ADR   = BITADDR'(NUMADDR - 1);
  localparam logic [7:0]         NPASS      = 8'(NUMPASS);
  localparam logic [DCW-1:0]     DRAIN_LOAD = DCW'(READ_DELAY - 1);

  function automatic logic [WIDTH-1:0] pat_w(input logic [BITADDR-1:0] a, input logic [7:0] s);
    logic [31:0]      v;
    logic [WIDTH-1:0] r;
    v = pat(32'(a), s);
    for (int i = 0; i < WIDTH; i++) r[i] = v[i % 32];
    return r;
  endfunction

  tg_state_e          state_q, state_d;
  logic [BITADDR-1:0] adr_q, adr_d;
  logic [7:0]         seed_q, seed_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic               clr;
  logic [WIDTH-1:0]   exp_data;

  logic               fail_q;
  logic [ERRW-1:0]    err_cnt_q;
  logic [BITADDR-1:0] err_adr_q;

  logic [PW-1:0]      pipe_q;
  logic               e_vld;
  logic [BITADDR-1:0] e_adr;
  logic [WIDTH-1:0]   e_data;
  logic               err_hit;
  logic               unused_serr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      seed_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      seed_q  <= seed_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    seed_d   = seed_q;
    drain_d  = drain_q;
    clr      = 1'b0;
    write    = 1'b0;
    wr_adr   = '0;
    din      = '0;
    read     = 1'b0;
    rd_adr   = '0;
    exp_data = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr     = 1'b1;
          seed_d  = '0;
          adr_d   = '0;
          state_d = ST_WAITRDY;
        end
      end
      ST_WAITRDY: begin
        if (ready) begin
          adr_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (ready) begin
          write  = 1'b1;
          wr_adr = adr_q;
          din    = pat_w(adr_q, 8'd0);
          if (adr_q == LAST_ADR) begin
            adr_d   = '0;
            seed_d  = 8'd1;
            state_d = ST_RW;
          end else begin
            adr_d = adr_q + 1'b1;
          end
        end
      end
      ST_RW: begin
        if (ready) begin
          read     = 1'b1;
          rd_adr   = adr_q;
          exp_data = pat_w(adr_q, seed_q - 8'd1);
          // Write trails the read by one address; nothing to write on the first cycle.
          if (adr_q != '0) begin
            write  = 1'b1;
            wr_adr = adr_q - 1'b1;
            din    = pat_w(adr_q - 1'b1, seed_q);
          end
          if (adr_q == LAST_ADR) state_d = ST_TAIL;
          else                   adr_d   = adr_q + 1'b1;
        end
      end
      ST_TAIL: begin
        if (ready) begin
          write  = 1'b1;
          wr_adr = LAST_ADR;
          din    = pat_w(LAST_ADR, seed_q);
          adr_d  = '0;
          if (seed_q == NPASS) begin
            state_d = ST_FINAL;
          end else begin
            seed_d  = seed_q + 8'd1;
            state_d = ST_RW;
          end
        end
      end
      ST_FINAL: begin
        if (ready) begin
          read     = 1'b1;
          rd_adr   = adr_q;
          exp_data = pat_w(adr_q, NPASS);
          if (adr_q == LAST_ADR) begin
            drain_d = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end else begin
            adr_d = adr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  algo_tg_exp_pipe #(
    .DEPTH (READ_DELAY),
    .W     (PW)
  ) u_exp_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({read, rd_adr, exp_data}),
    .q   (pipe_q)
  );

  assign {e_vld, e_adr, e_data} = pipe_q;
  assign unused_serr = rd_serr;

  assign err_hit = (e_vld != rd_vld)
                 | (e_vld & rd_vld & rd_derr)
                 | (e_vld & rd_vld & ~rd_derr & (rd_dout != e_data));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else if (clr) begin
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else if (err_hit) begin
      fail_q <= 1'b1;
      if (err_cnt_q != ERR_SAT[ERRW-1:0]) err_cnt_q <= err_cnt_q + 1'b1;
      if (err_cnt_q == '0)                err_adr_q <= e_adr;
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign fail     = fail_q;
  assign err_cnt  = err_cnt_q;
  assign err_adr  = err_adr_q;
  assign pass_cnt = seed_q;

endmodule
